// File: rtl/conv_ctrl_pkg.sv
// Shared types and address helpers for the convolution scheduler.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StCompute, StDrain} state_e;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Activation memory is laid out x-major, then y, then input channel.
    function automatic logic [31:0] act_addr(input logic [31:0] px, input logic [31:0] py,
                                             input logic [31:0] ch_in,
                                             input int unsigned fm_height,
                                             input int unsigned in_ch);
        return (px * fm_height + py) * in_ch + ch_in;
    endfunction

    function automatic logic [31:0] wgt_addr(input logic [31:0] ch_in, input logic [31:0] ch_out,
                                             input logic [31:0] tap,
                                             input int unsigned out_ch,
                                             input int unsigned taps);
        return (ch_in * out_ch + ch_out) * taps + tap;
    endfunction

endpackage

// File: rtl/conv_loop_nest.sv
// Six-deep counter chain (x, y, ch_out, ch_in, ky, kx), innermost kx, advancing on adv.
module conv_loop_nest #(
    parameter int unsigned FM_WIDTH    = 16,
    parameter int unsigned FM_HEIGHT   = 16,
    parameter int unsigned IN_CH       = 4,
    parameter int unsigned OUT_CH      = 32,
    parameter int unsigned KERNEL_SIZE = 3
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        adv,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [31:0] ch_out,
    output logic [31:0] ch_in,
    output logic [31:0] ky,
    output logic [31:0] kx,
    output logic        group_first,
    output logic        group_last,
    output logic        job_last
);

    logic kx_wrap, ky_wrap, ci_wrap, co_wrap, y_wrap, x_wrap;

    always_comb begin
        kx_wrap = (kx == KERNEL_SIZE - 1);
        ky_wrap = kx_wrap && (ky == KERNEL_SIZE - 1);
        ci_wrap = ky_wrap && (ch_in == IN_CH - 1);
        co_wrap = ci_wrap && (ch_out == OUT_CH - 1);
        y_wrap  = co_wrap && (y == FM_HEIGHT - 1);
        x_wrap  = y_wrap && (x == FM_WIDTH - 1);
    end

    assign group_first = (ch_in == '0) && (ky == '0) && (kx == '0);
    assign group_last  = ci_wrap;
    assign job_last    = x_wrap;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            x      <= '0;
            y      <= '0;
            ch_out <= '0;
            ch_in  <= '0;
            ky     <= '0;
            kx     <= '0;
        end else if (adv) begin
            kx <= kx_wrap ? '0 : kx + 32'd1;
            if (kx_wrap) ky <= ky_wrap ? '0 : ky + 32'd1;
            if (ky_wrap) ch_in <= ci_wrap ? '0 : ch_in + 32'd1;
            if (ci_wrap) ch_out <= co_wrap ? '0 : ch_out + 32'd1;
            if (co_wrap) y <= y_wrap ? '0 : y + 32'd1;
            if (y_wrap) x <= x_wrap ? '0 : x + 32'd1;
        end
    end

endmodule

// File: rtl/conv_sched_ctrl.sv
// Convolution scheduler: memory load, tap issue with address/pad generation, result tracking.
module conv_sched_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned FM_WIDTH    = 16,
    parameter int unsigned FM_HEIGHT   = 16,
    parameter int unsigned IN_CH       = 4,
    parameter int unsigned OUT_CH      = 32,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned DATA_LAT    = 2,
    localparam int unsigned A_DEPTH    = FM_WIDTH * FM_HEIGHT * IN_CH,
    localparam int unsigned B_DEPTH    = IN_CH * OUT_CH * KERNEL_SIZE * KERNEL_SIZE,
    localparam int unsigned A_AW       = addr_width(A_DEPTH),
    localparam int unsigned B_AW       = addr_width(B_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            start,
    input  logic            skip_load,
    output logic            running,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic            b_valid,
    output logic            b_ready,
    output logic            amem_we,
    output logic [A_AW-1:0] amem_waddr,
    output logic            bmem_we,
    output logic [B_AW-1:0] bmem_waddr,
    output logic [A_AW-1:0] a_raddr,
    output logic [B_AW-1:0] b_raddr,
    output logic            pad,
    output logic            mac_valid,
    output logic            mac_first,
    output logic            mac_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_x,
    output logic [31:0]     out_y,
    output logic [31:0]     out_ch,
    output logic            done
);

    localparam int unsigned HALF = KERNEL_SIZE / 2;
    localparam int unsigned TAPS = KERNEL_SIZE * KERNEL_SIZE;

    state_e state_q, state_d;
    logic [A_AW-1:0] a_cnt_q;
    logic [B_AW-1:0] b_cnt_q;
    logic a_hs, b_hs, a_wrap, b_wrap;

    logic [31:0] x, y, ch_out, ch_in, ky, kx;
    logic group_first, group_last, job_last;
    logic signed [32:0] px, py;
    logic pad_c, issue, marker_busy, out_hold, done_c;
    logic [A_AW-1:0] a_raddr_c;
    logic [B_AW-1:0] b_raddr_c;

    logic pad_q, mac_valid_q, mac_first_q, mac_last_q, out_valid_q;
    logic [A_AW-1:0] a_raddr_q;
    logic [B_AW-1:0] b_raddr_q;
    logic [31:0] out_x_q, out_y_q, out_ch_q;

    // Stage 0 is loaded together with the issue registers, so a marker spends DATA_LAT cycles here.
    logic [DATA_LAT-1:0] pipe_last;
    logic [DATA_LAT-1:0][31:0] pipe_x, pipe_y, pipe_ch;

    conv_loop_nest #(
        .FM_WIDTH   (FM_WIDTH),
        .FM_HEIGHT  (FM_HEIGHT),
        .IN_CH      (IN_CH),
        .OUT_CH     (OUT_CH),
        .KERNEL_SIZE(KERNEL_SIZE)
    ) u_loop_nest (
        .clk        (clk),
        .rst_in     (rst_in),
        .adv        (issue),
        .x          (x),
        .y          (y),
        .ch_out     (ch_out),
        .ch_in      (ch_in),
        .ky         (ky),
        .kx         (kx),
        .group_first(group_first),
        .group_last (group_last),
        .job_last   (job_last)
    );

    assign a_hs   = a_valid & a_ready;
    assign b_hs   = b_valid & b_ready;
    assign a_wrap = (a_cnt_q == A_AW'(A_DEPTH - 1));
    assign b_wrap = (b_cnt_q == B_AW'(B_DEPTH - 1));

    always_comb begin
        px = $signed({1'b0, x}) + $signed({1'b0, kx}) - $signed(33'(HALF));
        py = $signed({1'b0, y}) + $signed({1'b0, ky}) - $signed(33'(HALF));
        pad_c = px[32] || py[32] || (px >= $signed(33'(FM_WIDTH)))
                || (py >= $signed(33'(FM_HEIGHT)));
        a_raddr_c = pad_c ? '0 : A_AW'(act_addr(px[31:0], py[31:0], ch_in, FM_HEIGHT, IN_CH));
        b_raddr_c = B_AW'(wgt_addr(ch_in, ch_out, ky * KERNEL_SIZE + kx, OUT_CH, TAPS));
    end

    // A group's last tap waits until the single output buffer is guaranteed free.
    assign marker_busy = |pipe_last;
    assign out_hold    = out_valid_q & ~out_ready;
    assign issue       = (state_q == StCompute) & ~(group_last & (out_hold | marker_busy));
    assign done_c      = (state_q == StDrain) & out_valid_q & out_ready & ~marker_busy;

    always_ff @(posedge clk) begin
        if (rst_in) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = skip_load ? StCompute : StLoadA;
            StLoadA:   if (a_hs && a_wrap) state_d = StLoadB;
            StLoadB:   if (b_hs && b_wrap) state_d = StCompute;
            StCompute: if (issue && job_last) state_d = StDrain;
            StDrain:   if (done_c) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        running = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle:    ;
            StLoadA:   begin running = 1'b1; a_ready = 1'b1; end
            StLoadB:   begin running = 1'b1; b_ready = 1'b1; end
            StCompute: running = 1'b1;
            StDrain:   begin running = 1'b1; done = done_c; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            pad_q       <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            a_raddr_q   <= '0;
            b_raddr_q   <= '0;
            pipe_last   <= '0;
            pipe_x      <= '0;
            pipe_y      <= '0;
            pipe_ch     <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_ch_q    <= '0;
        end else begin
            if (state_q == StLoadA && a_hs) a_cnt_q <= a_wrap ? '0 : a_cnt_q + A_AW'(1);
            if (state_q == StLoadB && b_hs) b_cnt_q <= b_wrap ? '0 : b_cnt_q + B_AW'(1);

            mac_valid_q <= issue;
            mac_first_q <= issue & group_first;
            mac_last_q  <= issue & group_last;
            if (issue) begin
                pad_q     <= pad_c;
                a_raddr_q <= a_raddr_c;
                b_raddr_q <= b_raddr_c;
            end

            pipe_last[0] <= issue & group_last;
            pipe_x[0]    <= x;
            pipe_y[0]    <= y;
            pipe_ch[0]   <= ch_out;
            for (int unsigned i = 1; i < DATA_LAT; i++) begin
                pipe_last[i] <= pipe_last[i-1];
                pipe_x[i]    <= pipe_x[i-1];
                pipe_y[i]    <= pipe_y[i-1];
                pipe_ch[i]   <= pipe_ch[i-1];
            end

            if (pipe_last[DATA_LAT-1]) begin
                out_valid_q <= 1'b1;
                out_x_q     <= pipe_x[DATA_LAT-1];
                out_y_q     <= pipe_y[DATA_LAT-1];
                out_ch_q    <= pipe_ch[DATA_LAT-1];
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign amem_we    = a_hs;
    assign amem_waddr = a_cnt_q;
    assign bmem_we    = b_hs;
    assign bmem_waddr = b_cnt_q;
    assign a_raddr    = a_raddr_q;
    assign b_raddr    = b_raddr_q;
    assign pad        = pad_q;
    assign mac_valid  = mac_valid_q;
    assign mac_first  = mac_first_q;
    assign mac_last   = mac_last_q;
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_ch     = out_ch_q;

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Self-checking bench for conv_sched_ctrl on a 4x4x2 map, 2 output channels, 3x3 kernel.
module tb_conv_sched_ctrl;

    localparam int FW = 4, FH = 4, IC = 2, OC = 2, KS = 3, DL = 2, AAW = 5, BAW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_in = 1'b1, start = 1'b0, skip_load = 1'b0;
    logic a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b1;
    logic running, a_ready, b_ready, amem_we, bmem_we, pad, mac_valid, mac_first, mac_last;
    logic out_valid, done;
    logic [AAW-1:0] amem_waddr, a_raddr;
    logic [BAW-1:0] bmem_waddr, b_raddr;
    logic [31:0] out_x, out_y, out_ch;

    conv_sched_ctrl #(
        .FM_WIDTH(FW), .FM_HEIGHT(FH), .IN_CH(IC), .OUT_CH(OC), .KERNEL_SIZE(KS), .DATA_LAT(DL)
    ) dut (
        .clk(clk), .rst_in(rst_in), .start(start), .skip_load(skip_load), .running(running),
        .a_valid(a_valid), .a_ready(a_ready), .b_valid(b_valid), .b_ready(b_ready),
        .amem_we(amem_we), .amem_waddr(amem_waddr), .bmem_we(bmem_we), .bmem_waddr(bmem_waddr),
        .a_raddr(a_raddr), .b_raddr(b_raddr), .pad(pad), .mac_valid(mac_valid),
        .mac_first(mac_first), .mac_last(mac_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_ch(out_ch), .done(done)
    );

    wire [13:0]  tap_obs = {pad, a_raddr, b_raddr, mac_first, mac_last};
    wire [95:0]  res_obs = {out_x, out_y, out_ch};
    wire [128:0] all_out = {running, a_ready, b_ready, amem_we, amem_waddr, bmem_we, bmem_waddr,
                            a_raddr, b_raddr, pad, mac_valid, mac_first, mac_last, out_valid,
                            out_x, out_y, out_ch, done};

    int n_cmp = 0, n_bad = 0, res_seen = 0;
    bit sb_en = 1'b0;
    logic [13:0] tap_q[$];
    logic [95:0] res_q[$];
    logic [13:0] exp_tap;
    logic [95:0] exp_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference schedule: expected taps and results in loop order for one job.
    task automatic fill_model();
        int px, py, a, b;
        logic pd;
        tap_q.delete();
        res_q.delete();
        res_seen = 0;
        for (int x = 0; x < FW; x++)
            for (int y = 0; y < FH; y++)
                for (int co = 0; co < OC; co++) begin
                    res_q.push_back({32'(x), 32'(y), 32'(co)});
                    for (int ci = 0; ci < IC; ci++)
                        for (int ky = 0; ky < KS; ky++)
                            for (int kx = 0; kx < KS; kx++) begin
                                px = x + kx - KS / 2;
                                py = y + ky - KS / 2;
                                pd = (px < 0) || (px >= FW) || (py < 0) || (py >= FH);
                                a  = pd ? 0 : (px * FH + py) * IC + ci;
                                b  = (ci * OC + co) * KS * KS + ky * KS + kx;
                                tap_q.push_back({pd, 5'(a), 6'(b),
                                                 1'(ci == 0 && ky == 0 && kx == 0),
                                                 1'(ci == IC - 1 && ky == KS - 1 && kx == KS - 1)});
                            end
                end
    endtask

    always @(negedge clk) begin
        if (sb_en) begin
            if (mac_valid) begin
                n_cmp++;
                if (tap_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL tap_extra: got tap %h, required no tap", tap_obs);
                end else begin
                    exp_tap = tap_q.pop_front();
                    if (tap_obs !== exp_tap) begin
                        n_bad++;
                        $display("FAIL tap: got %h, required %h", tap_obs, exp_tap);
                    end
                end
            end else if (mac_first || mac_last) begin
                n_cmp++;
                n_bad++;
                $display("FAIL idle_flags: got first=%b last=%b, required 0", mac_first, mac_last);
            end
            if (out_valid && out_ready) begin
                res_seen++;
                n_cmp++;
                if (res_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL result_extra: got %h, required no result", res_obs);
                end else begin
                    exp_res = res_q.pop_front();
                    if (res_obs !== exp_res) begin
                        n_bad++;
                        $display("FAIL result: got %h, required %h", res_obs, exp_res);
                    end
                end
                n_cmp++;
                if (done !== (res_q.size() == 0)) begin
                    n_bad++;
                    $display("FAIL done_pulse: got %b, required %b", done, res_q.size() == 0);
                end
            end
        end
    end

    task automatic wait_done(input int limit, output bit seen, output bit rdy_seen);
        seen = 1'b0;
        rdy_seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            @(negedge clk);
            if (a_ready || b_ready) rdy_seen = 1'b1;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_load();
        int exp_a;
        int guard;
        bit tog;
        fill_model();
        sb_en = 1'b1;
        start = 1'b1;
        skip_load = 1'b0;
        tick();
        start = 1'b0;
        exp_a = 0;
        guard = 0;
        tog = 1'b1;
        while (exp_a < FW * FH * IC && guard < 200) begin
            a_valid = tog;
            @(negedge clk);
            n_cmp++;
            if ({a_ready, b_ready, amem_we, amem_waddr} !== {1'b1, 1'b0, a_valid, 5'(exp_a)}) begin
                n_bad++;
                $display("FAIL load_a: got %b, required %b", {a_ready, b_ready, amem_we, amem_waddr},
                         {1'b1, 1'b0, a_valid, 5'(exp_a)});
            end
            if (a_valid) exp_a++;
            tog = !tog;
            guard++;
            tick();
        end
        a_valid = 1'b0;
        exp_a = 0;
        guard = 0;
        tog = 1'b1;
        while (exp_a < IC * OC * KS * KS && guard < 200) begin
            b_valid = tog;
            @(negedge clk);
            n_cmp++;
            if ({a_ready, b_ready, bmem_we, bmem_waddr} !== {1'b0, 1'b1, b_valid, 6'(exp_a)}) begin
                n_bad++;
                $display("FAIL load_b: got %b, required %b", {a_ready, b_ready, bmem_we, bmem_waddr},
                         {1'b0, 1'b1, b_valid, 6'(exp_a)});
            end
            if (b_valid) exp_a++;
            tog = !tog;
            guard++;
            tick();
        end
        b_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({running, a_ready, b_ready, mac_valid} !== 4'b1000) begin
            n_bad++;
            $display("FAIL enter_compute: got %b, required 1000",
                     {running, a_ready, b_ready, mac_valid});
        end
    endtask

    task automatic test_first_group();
        int idx = 0, cyc = 0, c_last = -1, c_out = -1;
        for (int g = 0; g < 100 && idx < 36; g++) begin
            tick();
            @(negedge clk);
            cyc++;
            if (g == 0) begin
                n_cmp++;
                if (mac_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL first_issue: got mac_valid=%b, required 1", mac_valid);
                end
            end
            if (out_valid && c_out < 0) c_out = cyc;
            if (mac_valid) begin
                case (idx)
                    0: begin
                        n_cmp++;
                        if ({pad, a_raddr, mac_first} !== {1'b1, 5'd0, 1'b1}) begin
                            n_bad++;
                            $display("FAIL tap0: got %b, required 1000001", {pad, a_raddr, mac_first});
                        end
                    end
                    4: begin
                        n_cmp++;
                        if ({pad, a_raddr} !== {1'b0, 5'd0}) begin
                            n_bad++;
                            $display("FAIL tap4: got %b, required 000000", {pad, a_raddr});
                        end
                    end
                    8: begin
                        n_cmp++;
                        if ({pad, a_raddr} !== {1'b0, 5'd10}) begin
                            n_bad++;
                            $display("FAIL tap8: got pad=%b a=%0d, required pad=0 a=10", pad, a_raddr);
                        end
                    end
                    17: begin
                        c_last = cyc;
                        n_cmp++;
                        if (mac_last !== 1'b1) begin
                            n_bad++;
                            $display("FAIL group0_last: got %b, required 1", mac_last);
                        end
                    end
                    35: begin
                        n_cmp++;
                        if ({b_raddr, mac_last} !== {6'd35, 1'b1}) begin
                            n_bad++;
                            $display("FAIL wgt35: got b=%0d last=%b, required b=35 last=1",
                                     b_raddr, mac_last);
                        end
                    end
                    default: ;
                endcase
                idx++;
            end
        end
        n_cmp++;
        if (idx != 36) begin
            n_bad++;
            $display("FAIL first_taps: got %0d taps, required 36", idx);
        end
        n_cmp++;
        if (c_last < 0 || c_out - c_last != DL) begin
            n_bad++;
            $display("FAIL first_result_lat: got %0d, required %0d", c_out - c_last, DL);
        end
    endtask

    task automatic test_backpressure();
        bit got = 1'b0;
        int zc = 0;
        logic [95:0] held;
        tick();
        out_ready = 1'b0;
        for (int g = 0; g < 40 && !got; g++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL bp_wait_valid: got out_valid=0, required 1 within 40 cycles");
        end
        held = res_obs;
        for (int g = 0; g < 80 && zc < 6; g++) begin
            tick();
            @(negedge clk);
            n_cmp++;
            if ({out_valid, res_obs, mac_last} !== {1'b1, held, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_hold: got v=%b r=%h l=%b, required v=1 r=%h l=0",
                         out_valid, res_obs, mac_last, held);
            end
            if (mac_valid) zc = 0;
            else zc++;
        end
        n_cmp++;
        if (zc < 6) begin
            n_bad++;
            $display("FAIL bp_stall: got %0d idle cycles, required 6", zc);
        end
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({mac_valid, mac_last} !== 2'b11) begin
            n_bad++;
            $display("FAIL bp_resume: got %b, required 11", {mac_valid, mac_last});
        end
    endtask

    task automatic check_job_end(input string name, input bit seen);
        tick();
        @(negedge clk);
        n_cmp++;
        if ({seen, running, done, 32'(res_seen), 32'(tap_q.size())} !== {3'b100, 32'd32, 32'd0}) begin
            n_bad++;
            $display("FAIL %s: got seen=%b run=%b done=%b res=%0d taps_left=%0d, required 1 0 0 32 0",
                     name, seen, running, done, res_seen, tap_q.size());
        end
    endtask

    task automatic test_full_job();
        bit seen, rdy;
        wait_done(1500, seen, rdy);
        check_job_end("full_job", seen);
    endtask

    task automatic test_skip_load();
        bit seen, rdy;
        fill_model();
        tick();
        start = 1'b1;
        skip_load = 1'b1;
        tick();
        start = 1'b0;
        skip_load = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({running, a_ready, b_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL skip_enter: got %b, required 100", {running, a_ready, b_ready});
        end
        wait_done(1500, seen, rdy);
        n_cmp++;
        if (rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL skip_no_ready: got ready seen=%b, required 0", rdy);
        end
        check_job_end("skip_job", seen);
    endtask

    task automatic test_reset_mid();
        bit seen, rdy;
        fill_model();
        tick();
        start = 1'b1;
        skip_load = 1'b1;
        tick();
        start = 1'b0;
        skip_load = 1'b0;
        repeat (100) tick();
        sb_en = 1'b0;
        rst_in = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h, required 0", all_out);
        end
        tick();
        rst_in = 1'b0;
        fill_model();
        sb_en = 1'b1;
        tick();
        start = 1'b1;
        skip_load = 1'b1;
        tick();
        start = 1'b0;
        skip_load = 1'b0;
        wait_done(1500, seen, rdy);
        check_job_end("after_reset_job", seen);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load();
        test_first_group();
        test_backpressure();
        test_full_job();
        test_skip_load();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_sched_ctrl.md
Name: conv_sched_ctrl

Overview:
Parametrised scheduler for the convolution accelerator. It loads the activation and weight memories through valid/ready streams, then walks every output pixel and output channel, and for each one sequences all input channels and kernel taps. It issues one tap per cycle and generates memory addresses, zero-pad selects and MAC control. Completed outputs are presented on a single-entry valid/ready output port that applies back-pressure to the schedule. It replaces the fixed-size, fixed-3x3 controller.

Parameters:
FM_WIDTH, 16, feature-map width (x extent)
FM_HEIGHT, 16, feature-map height (y extent)
IN_CH, 4, input channels
OUT_CH, 32, output channels
KERNEL_SIZE, 3, odd kernel edge K; taps per channel = K*K
DATA_LAT, 2, cycles from tap issue (mac_valid) to MAC result including that tap; >=1
Derived localparams: A_DEPTH = FM_WIDTH*FM_HEIGHT*IN_CH; B_DEPTH = IN_CH*OUT_CH*K*K; A_AW = $clog2(A_DEPTH); B_AW = $clog2(B_DEPTH)

Ports:
clk  in  1  clock
rst_in  in  1  reset, synchronous, active-high
start  in  1  begin job; sampled only in IDLE
skip_load  in  1  sampled with start; 1 = reuse memory contents and go straight to COMPUTE
running  out  1  high in LOAD_A, LOAD_B, COMPUTE and DRAIN
a_valid / a_ready  in / out  1 / 1  activation load stream handshake
b_valid / b_ready  in / out  1 / 1  weight load stream handshake
amem_we  out  1  a_valid & a_ready
amem_waddr  out  A_AW  load write address
bmem_we  out  1  b_valid & b_ready
bmem_waddr  out  B_AW  load write address
a_raddr  out  A_AW  activation read address for the issued tap
b_raddr  out  B_AW  weight read address for the issued tap
pad  out  1  issued tap lies outside the map; the datapath substitutes 0
mac_valid  out  1  a tap is issued this cycle
mac_first  out  1  first tap of an output group (ch_in=0, tap=0); clears the accumulator
mac_last  out  1  last tap of an output group
out_valid / out_ready  out / in  1 / 1  result handshake
out_x, out_y, out_ch  out  32 each  coordinates of the presented result
done  out  1  one-cycle pulse when the last result is accepted

Behaviour:
- Reset: state IDLE; all counters, addresses and outputs 0. Reset mid-operation aborts the job; all outputs are 0 in the cycle after reset is asserted, and the in-flight pipeline is discarded.
- States and transitions:
  - IDLE -> LOAD_A on start & !skip_load; IDLE -> COMPUTE on start & skip_load.
  - LOAD_A: a_ready=1. amem_waddr advances only on a handshake. After the handshake at address A_DEPTH-1, go to LOAD_B with the address wrapped to 0. a_valid low means wait, no timeout.
  - LOAD_B: same rules with b_ready and B_DEPTH. After the last handshake, go to COMPUTE.
  - COMPUTE: issue one tap per cycle unless stalled. After the final tap is issued, go to DRAIN.
  - DRAIN: wait until the final result is accepted, then pulse done and go to IDLE.
- Loop order, outer to inner: x, y, ch_out, ch_in, ky, kx. Each counter wraps to 0 when all inner counters wrap.
- Tap index t = ky*K + kx. Pixel coordinates px = x+kx-K/2, py = y+ky-K/2, computed signed at 33 bits.
- pad = (px<0 | px>=FM_WIDTH | py<0 | py>=FM_HEIGHT).
- a_raddr = (px*FM_HEIGHT + py)*IN_CH + ch_in when not padded, else 0.
- b_raddr = (ch_in*OUT_CH + ch_out)*K*K + t.
- All issue outputs (addresses, pad, mac_valid, mac_first, mac_last) are registered and align with one another. mac_valid=0 forces mac_first and mac_last to 0.
- Result tracking: a shift register of depth DATA_LAT carries {mac_last, x, y, ch_out}. When the last-tap marker exits, the result loads the output buffer and out_valid rises in that same cycle. out_valid holds until out_valid & out_ready.
- Stall rule: issuing a mac_last tap is blocked while (out_valid & !out_ready) or a mac_last marker is still inside the shift register. While stalled, mac_valid=0 and all counters hold. Other taps issue freely.
- Simultaneous events: acceptance and a new load of the buffer in the same cycle leave out_valid=1 with the new coordinates. start outside IDLE is ignored.
- done is asserted in the same cycle the last result handshakes.
- Total results per job = FM_WIDTH*FM_HEIGHT*OUT_CH.

Decomposition:
- Package conv_ctrl_pkg: state enum (IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN) and helper functions for address formulas and clog2-derived widths.
- One sub-module, conv_loop_nest: a parametrised counter chain (x, y, ch_out, ch_in, ky, kx) with an advance enable and wrap/last flags. The FSM, address generation, result tracking and output buffer stay in conv_sched_ctrl.

Test Plan:
Test parameters: FM 4x4, IN_CH=2, OUT_CH=2, K=3, DATA_LAT=2, so A_DEPTH=32 and B_DEPTH=36.
- Load with bursts: a_valid toggling 1,0,1,... -> amem_waddr steps 0..31 only on handshakes; then bmem_waddr 0..35; COMPUTE is entered on the cycle after b handshake 35.
- First group (x=0, y=0, ch_out=0, ch_in=0): tap 0 -> pad=1, a_raddr=0, mac_first=1; tap 4 -> pad=0, a_raddr=0; tap 8 -> a_raddr=(1*4+1)*2=10.
- Weight address at ch_in=1, ch_out=1, t=8 -> b_raddr=35 with mac_last=1. The first result (0,0,0) appears DATA_LAT cycles after the first group's mac_last.
- Back-pressure: hold out_ready=0 for 6 cycles -> out_valid and out_x/out_y/out_ch stay stable; no mac_last is issued; issue resumes the cycle after acceptance.
- Full job with out_ready=1 -> exactly 32 results in loop order, done pulses once, state returns to IDLE. Then start with skip_load=1 -> no a_ready or b_ready asserted, and compute restarts at (0,0,0).
- Assert rst_in mid-COMPUTE -> next cycle all outputs 0 and state IDLE; a new start with skip_load=1 reproduces the first result sequence.
